// File: rtl/fios_norm_pkg.sv
// Shared definitions for the FIOS result normalizer.
//   norm_state_e : controller states (IDLE, ACCUM, FLUSH)
//   count_width  : width of the per-operation word counter, sized so that
//                  WORD_COUNT itself is representable.
package fios_norm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } norm_state_e;

  function automatic int count_width(input int word_count);
    return $clog2(word_count + 1);
  endfunction

endpackage

// File: rtl/fios_carry_add.sv
// Combinational digit/carry split for the normalizer.
//   p         : 2W-bit redundant DSP word
//   carry_in  : W+1-bit carry from the previous digit position
//   digit     : low W bits of p + carry_in
//   carry_out : remaining high W+1 bits, which feed the next position
// The sum is below 2^(2W) + 2^(W+1), so bit 2W is the top carry bit and
// nothing is lost. Kept separate so it can be retimed or pipelined later.
module fios_carry_add #(
  parameter int WORD_WIDTH = 23
) (
  input  logic [2*WORD_WIDTH-1:0] p,
  input  logic [WORD_WIDTH:0]     carry_in,
  output logic [WORD_WIDTH-1:0]   digit,
  output logic [WORD_WIDTH:0]     carry_out
);

  logic [2*WORD_WIDTH:0] acc;

  always_comb begin
    acc       = {1'b0, p} + {{(WORD_WIDTH){1'b0}}, carry_in};
    digit     = acc[WORD_WIDTH-1:0];
    carry_out = acc[2*WORD_WIDTH:WORD_WIDTH];
  end

endmodule

// File: rtl/fios_result_normalizer.sv
// Carry-propagating normalizer at the output of the cascaded DSP chain.
// Takes 2W-bit partial-product words (LS first, weight 2^(W*k)) and emits
// WORD_COUNT non-redundant W-bit digits followed by one flush digit that
// holds the residual carry.
// Ports:
//   clock_i, reset_i          : rising-edge clock, synchronous active-high reset
//   start_i                   : opens a new operation (also aborts a running one)
//   P_valid_i, P_i            : DSP output word, no backpressure
//   res_valid_o, res_o        : normalized digit, one cycle after its input
//   res_last_o, done_o        : flag the flush digit
//   overflow_o                : top carry bit of the final carry, sticky
//   protocol_err_o            : sticky, set by a word arriving outside ACCUM
import fios_norm_pkg::*;

module fios_result_normalizer #(
  parameter int WORD_WIDTH = 23,
  parameter int WORD_COUNT = 12
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    P_valid_i,
  input  logic [2*WORD_WIDTH-1:0] P_i,
  output logic                    res_valid_o,
  output logic [WORD_WIDTH-1:0]   res_o,
  output logic                    res_last_o,
  output logic                    done_o,
  output logic                    overflow_o,
  output logic                    protocol_err_o
);

  localparam int              CW       = count_width(WORD_COUNT);
  localparam logic [CW-1:0]   LAST_IDX = CW'(WORD_COUNT - 1);

  norm_state_e             state;
  logic [WORD_WIDTH:0]     carry;
  logic [CW-1:0]           count;

  // start_i acts as if the operation had just been opened from IDLE, so a
  // word arriving with it sees a cleared carry and count.
  logic [WORD_WIDTH:0]     carry_in;
  logic [CW-1:0]           count_in;
  logic [WORD_WIDTH-1:0]   digit;
  logic [WORD_WIDTH:0]     carry_nxt;
  logic                    accepting;

  always_comb begin
    carry_in  = start_i ? '0 : carry;
    count_in  = start_i ? '0 : count;
    accepting = start_i || (state == ACCUM);
  end

  fios_carry_add #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_carry_add (
    .p         (P_i),
    .carry_in  (carry_in),
    .digit     (digit),
    .carry_out (carry_nxt)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state          <= IDLE;
      carry          <= '0;
      count          <= '0;
      res_valid_o    <= 1'b0;
      res_o          <= '0;
      res_last_o     <= 1'b0;
      done_o         <= 1'b0;
      overflow_o     <= 1'b0;
      protocol_err_o <= 1'b0;
    end else begin
      // Output strobes are single-cycle unless re-asserted below.
      res_valid_o <= 1'b0;
      res_last_o  <= 1'b0;
      done_o      <= 1'b0;

      if (start_i) begin
        overflow_o     <= 1'b0;
        protocol_err_o <= 1'b0;
      end

      if (accepting) begin
        // ACCUM, or any state with start_i: a pending flush is dropped.
        if (P_valid_i) begin
          res_valid_o <= 1'b1;
          res_o       <= digit;
          carry       <= carry_nxt;
          if (count_in == LAST_IDX) begin
            state <= FLUSH;
            count <= '0;
          end else begin
            state <= ACCUM;
            count <= count_in + CW'(1);
          end
        end else begin
          state <= ACCUM;
          count <= count_in;
          carry <= carry_in;
        end
      end else if (state == FLUSH) begin
        // Single flush cycle: residual carry goes out as the last digit.
        res_valid_o <= 1'b1;
        res_o       <= carry[WORD_WIDTH-1:0];
        res_last_o  <= 1'b1;
        done_o      <= 1'b1;
        overflow_o  <= carry[WORD_WIDTH];
        carry       <= '0;
        state       <= IDLE;
        if (P_valid_i) protocol_err_o <= 1'b1;
      end else begin
        // IDLE: a stray word is dropped and flagged.
        if (P_valid_i) protocol_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fios_result_normalizer.sv
module tb_fios_result_normalizer;

  typedef struct {
    logic [7:0] res;
    logic       last;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  logic        start3, pv3;
  logic [15:0] p3;
  logic        rv3, rl3, dn3, ov3, er3;
  logic [7:0]  r3;

  logic        start2, pv2;
  logic [15:0] p2;
  logic        rv2, rl2, dn2, ov2, er2;
  logic [7:0]  r2;

  exp_t q3[$];
  exp_t q2[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fios_result_normalizer #(.WORD_WIDTH(8), .WORD_COUNT(3)) u3 (
    .clock_i(clk), .reset_i(rst), .start_i(start3), .P_valid_i(pv3), .P_i(p3),
    .res_valid_o(rv3), .res_o(r3), .res_last_o(rl3), .done_o(dn3),
    .overflow_o(ov3), .protocol_err_o(er3));

  fios_result_normalizer #(.WORD_WIDTH(8), .WORD_COUNT(2)) u2 (
    .clock_i(clk), .reset_i(rst), .start_i(start2), .P_valid_i(pv2), .P_i(p2),
    .res_valid_o(rv2), .res_o(r2), .res_last_o(rl2), .done_o(dn2),
    .overflow_o(ov2), .protocol_err_o(er2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic d3(input logic st, input logic v, input logic [15:0] p);
    tick(); start3 = st; pv3 = v; p3 = p;
  endtask

  task automatic d2(input logic st, input logic v, input logic [15:0] p);
    tick(); start2 = st; pv2 = v; p2 = p;
  endtask

  // Expected word appears dly cycles after the currently driven input cycle.
  task automatic e3(input logic [7:0] res, input logic last, input logic ovf, input int dly);
    exp_t e; e.res = res; e.last = last; e.ovf = ovf; e.cyc = cyc + dly; q3.push_back(e);
  endtask

  task automatic e2(input logic [7:0] res, input logic last, input logic ovf, input int dly);
    exp_t e; e.res = res; e.last = last; e.ovf = ovf; e.cyc = cyc + dly; q2.push_back(e);
  endtask

  // Monitors: every presented word must match the head of its queue.
  always @(negedge clk) begin
    if (rv3) begin
      if (q3.size() == 0) check("u3_unexpected_word", {24'h0, r3}, 32'hFFFF_FFFF);
      else begin
        exp_t e; e = q3.pop_front();
        check("u3_res", r3, e.res);
        check("u3_last", rl3, e.last);
        check("u3_done", dn3, e.last);
        check("u3_latency", cyc, e.cyc);
        if (e.last) check("u3_overflow", ov3, e.ovf);
      end
    end else if (rl3 || dn3) check("u3_stray_last_done", {rl3, dn3}, 0);
  end

  always @(negedge clk) begin
    if (rv2) begin
      if (q2.size() == 0) check("u2_unexpected_word", {24'h0, r2}, 32'hFFFF_FFFF);
      else begin
        exp_t e; e = q2.pop_front();
        check("u2_res", r2, e.res);
        check("u2_last", rl2, e.last);
        check("u2_done", dn2, e.last);
        check("u2_latency", cyc, e.cyc);
        if (e.last) check("u2_overflow", ov2, e.ovf);
      end
    end else if (rl2 || dn2) check("u2_stray_last_done", {rl2, dn2}, 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start3 = 0; pv3 = 0; p3 = '0;
    start2 = 0; pv2 = 0; p2 = '0;
    tick(); tick();
    check("rst_u3_valid", rv3, 0);
    check("rst_u3_res", r3, 0);
    check("rst_u3_last_done", {rl3, dn3}, 0);
    check("rst_u3_ovf_err", {ov3, er3}, 0);
    check("rst_u2_ovf_err", {ov2, er2, rv2}, 0);
    rst = 1'b0;

    // Scenario 1: FFFF, FFFF, 0001 -> FF, FE, 01, flush 01 (0x0101FEFF)
    d3(1, 0, 16'h0);
    d3(0, 1, 16'hFFFF); e3(8'hFF, 0, 0, 1);
    d3(0, 1, 16'hFFFF); e3(8'hFE, 0, 0, 1);
    d3(0, 1, 16'h0001); e3(8'h01, 0, 0, 1); e3(8'h01, 1, 0, 2);
    repeat (4) d3(0, 0, 16'h0);
    check("s1_err", er3, 0);

    // Gapped input: same results, each one cycle after its input
    d3(1, 0, 16'h0);
    d3(0, 1, 16'hFFFF); e3(8'hFF, 0, 0, 1);
    d3(0, 0, 16'h0); d3(0, 0, 16'h0);
    d3(0, 1, 16'hFFFF); e3(8'hFE, 0, 0, 1);
    d3(0, 0, 16'h0); d3(0, 0, 16'h0);
    d3(0, 1, 16'h0001); e3(8'h01, 0, 0, 1); e3(8'h01, 1, 0, 2);
    repeat (4) d3(0, 0, 16'h0);

    // Abort after 2 words; restart start coincides with first new word
    d3(1, 0, 16'h0);
    d3(0, 1, 16'hFFFF); e3(8'hFF, 0, 0, 1);
    d3(0, 1, 16'hFFFF); e3(8'hFE, 0, 0, 1);
    d3(1, 1, 16'hFFFF); e3(8'hFF, 0, 0, 1);
    d3(0, 1, 16'hFFFF); e3(8'hFE, 0, 0, 1);
    d3(0, 1, 16'h0001); e3(8'h01, 0, 0, 1); e3(8'h01, 1, 0, 2);
    repeat (4) d3(0, 0, 16'h0);
    check("abort_err", er3, 0);
    check("abort_ovf", ov3, 0);

    // Stray word in IDLE: no output, error set, then cleared by start
    d3(0, 1, 16'h1234);
    d3(0, 0, 16'h0);
    check("idle_word_err_set", er3, 1);
    d3(0, 0, 16'h0);
    check("idle_word_err_sticky", er3, 1);
    d3(1, 0, 16'h0);
    d3(0, 0, 16'h0);
    check("start_clears_err", er3, 0);

    // WORD_COUNT=2 overflow; a word in the FLUSH cycle is flagged and ignored
    d2(1, 0, 16'h0);
    d2(0, 1, 16'hFFFF); e2(8'hFF, 0, 0, 1);
    d2(0, 1, 16'hFFFF); e2(8'hFE, 0, 0, 1); e2(8'h00, 1, 1, 2);
    d2(0, 1, 16'h5555);
    d2(0, 0, 16'h0);
    check("u2_flush_word_err", er2, 1);
    repeat (3) d2(0, 0, 16'h0);
    check("u2_ovf_sticky", ov2, 1);
    d2(1, 0, 16'h0);
    d2(0, 0, 16'h0);
    check("u2_start_clears_ovf_err", {ov2, er2}, 0);

    // Reset in the cycle after the 2nd word: nothing further emitted
    d3(1, 0, 16'h0);
    d3(0, 1, 16'hFFFF); e3(8'hFF, 0, 0, 1);
    d3(0, 1, 16'hFFFF); e3(8'hFE, 0, 0, 1);
    tick(); rst = 1'b1; pv3 = 1'b1; p3 = 16'h0001;
    tick(); rst = 1'b0; pv3 = 1'b0; p3 = '0;
    check("rst_mid_valid", rv3, 0);
    repeat (4) d3(0, 0, 16'h0);
    check("rst_mid_flags", {rv3, ov3, er3}, 0);
    // After reset the block must be IDLE: a bare word is a protocol error
    d3(0, 1, 16'h00AA);
    d3(0, 0, 16'h0);
    check("rst_mid_idle", er3, 1);
    repeat (3) d3(0, 0, 16'h0);

    check("u3_queue_drained", q3.size(), 0);
    check("u2_queue_drained", q2.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
